vga_vram_arbiter: RTL and testbench
===================================

// Module: vga_vram_arbiter
// PURPOSE
//  Shares the single-port VRAM between the VGA scanout pixel fetch and CPU accesses.
//  Scanout has priority during active video; the CPU has priority during h/v blanking.
//  A starvation counter forces a CPU grant after STARVE_LIMIT lost cycles.
//  Sits between vga_vram_interface, the CPU I/O path and the VRAM pins.
// PARAMETERS
//  VRAM_DATA_WIDTH  16  VRAM word width
//  VRAM_ADDR_WIDTH  17  VRAM word address width
//  STARVE_LIMIT     8   max consecutive lost CPU cycles before forced grant; legal 1..255
//  STAT_WIDTH       16  width of statistics counters
// PORTS
//  clock         in   1    system clock
//  reset         in   1    synchronous, active-low reset
//  hblank        in   1    horizontal blanking from sync generator
//  vblank        in   1    vertical blanking from sync generator
//  scan_req      in   1    scanout read request; held with scan_addr until scan_gnt
//  scan_addr     in   VA   scanout read address
//  scan_gnt      out  1    scanout request accepted this cycle
//  scan_rdata    out  VD   scanout read data
//  scan_rvalid   out  1    scan_rdata valid (1-cycle pulse)
//  cpu_req       in   1    CPU request; held with cpu_we/addr/wdata until cpu_gnt
//  cpu_we        in   1    1=write, 0=read
//  cpu_addr      in   VA   CPU address
//  cpu_wdata     in   VD   CPU write data
//  cpu_gnt       out  1    CPU request accepted this cycle
//  cpu_rdata     out  VD   CPU read data
//  cpu_rvalid    out  1    cpu_rdata valid (1-cycle pulse; reads only)
//  vram_en       out  1    VRAM access strobe
//  vram_we       out  1    VRAM write enable
//  vram_addr     out  VA   VRAM address
//  vram_wdata    out  VD   VRAM write data
//  vram_rdata    in   VD   VRAM read data; valid 1 cycle after vram_en (sync SRAM)
//  stat_clear    in   1    clears statistics counters
//  stat_cpu_wait out  SW   cycles with cpu_req && !cpu_gnt
//  stat_scan_def out  SW   active-video cycles with scan_req && !scan_gnt
// BEHAVIOUR
//  - Reset (reset==0 at a clock edge): every output 0, starve counter 0, pipeline tags cleared.
//  - Grant (combinational, cycle N), at most one grant per cycle:
//      blank = hblank|vblank
//      blank: cpu_req wins; else scan_req.
//      !blank: starve==STARVE_LIMIT && cpu_req -> CPU; else scan_req wins; else cpu_req.
//  - Starve counter: +1 each cycle cpu_req && !cpu_gnt, saturates at STARVE_LIMIT;
//    cleared in the cycle cpu_gnt=1 or cpu_req=0.
//  - Cycle N+1: vram_en=1, vram_we/addr/wdata registered from the granted requester;
//    a scanout grant always drives vram_we=0. No grant -> vram_en=0, vram_we=0.
//  - Cycle N+2: for a read, the owner's rvalid=1 with rdata=vram_rdata; the other rvalid=0.
//    Writes produce no rvalid. A 2-stage owner/read tag pipeline tracks this.
//  - Back-to-back grants are legal every cycle; there are no bubbles between owners.
//  - rdata holds its last value when rvalid=0.
//  - Reset during N+1/N+2 drops in-flight reads: no rvalid is produced.
//  - A requester dropping req before gnt is a protocol violation; behaviour is undefined.
//  - blank toggling while CPU is starved: blank priority applies immediately; counter clears on grant.
// CONFIGURATION
//  VGA_VRAM_ARB_STATS_EN defined:
//    - stat_cpu_wait and stat_scan_def are saturating up-counters (all-ones max).
//    - stat_clear has priority over increment; counters read 0 the cycle after a clear.
//  Undefined:
//    - Counters are not built; stat_* ports remain present, driven 0; stat_clear is ignored.
// TESTING
//  1 active video, scan_req=cpu_req=1, starve=0 -> scan_gnt=1, cpu_gnt=0; starve=1 next cycle.
//  2 active video, scan_req, cpu_req held, STARVE_LIMIT=8 -> cpu_gnt=1 in 9th cycle only;
//    scan_gnt in the other 8; starve=0 after.
//  3 vblank=1, both req -> cpu_gnt=1, scan_gnt=0 every cycle cpu_req held.
//  4 CPU read 0x1ABCD, model returns 0xBEEF -> N+1: vram_en=1, vram_we=0, addr=0x1ABCD;
//    N+2: cpu_rvalid=1, cpu_rdata=0xBEEF, scan_rvalid=0.
//  5 scan grant at N, reset=0 at N+1 edge -> no scan_rvalid at N+2; all outputs 0.
//  6 STATS_EN: 5 CPU wait cycles -> stat_cpu_wait=5; stat_clear -> 0;
//    without macro stat_*=0 throughout.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scanout wins during active video, CPU wins in blanking,
// with a starvation override. Optional statistics counters: VGA_VRAM_ARB_STATS_EN.
module vga_vram_arbiter #(
    parameter int VRAM_DATA_WIDTH = 16,
    parameter int VRAM_ADDR_WIDTH = 17,
    parameter int STARVE_LIMIT    = 8,
    parameter int STAT_WIDTH      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       hblank,
    input  logic                       vblank,
    input  logic                       scan_req,
    input  logic [VRAM_ADDR_WIDTH-1:0] scan_addr,
    output logic                       scan_gnt,
    output logic [VRAM_DATA_WIDTH-1:0] scan_rdata,
    output logic                       scan_rvalid,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [VRAM_DATA_WIDTH-1:0] cpu_wdata,
    output logic                       cpu_gnt,
    output logic [VRAM_DATA_WIDTH-1:0] cpu_rdata,
    output logic                       cpu_rvalid,
    output logic                       vram_en,
    output logic                       vram_we,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
    output logic [VRAM_DATA_WIDTH-1:0] vram_wdata,
    input  logic [VRAM_DATA_WIDTH-1:0] vram_rdata,
    input  logic                       stat_clear,
    output logic [STAT_WIDTH-1:0]      stat_cpu_wait,
    output logic [STAT_WIDTH-1:0]      stat_scan_def
);

    localparam int STAGES = 2;
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    typedef struct packed {
        logic                       we;
        logic [VRAM_ADDR_WIDTH-1:0] addr;
        logic [VRAM_DATA_WIDTH-1:0] wdata;
    } vram_req_t;

    logic                       blank;
    logic                       force_cpu;
    logic                       rd_issue;
    vram_req_t                  gnt_req;
    logic [7:0]                 starve;
    logic [STAGES:1]            vld_pipe;
    logic [STAGES:1]            own_pipe;   // 1 = CPU owns the read in flight
    logic [VRAM_DATA_WIDTH-1:0] cpu_rdata_q;
    logic [VRAM_DATA_WIDTH-1:0] scan_rdata_q;

    assign blank     = hblank | vblank;
    assign force_cpu = (starve == STARVE_MAX) && cpu_req;

    // Grants are masked while reset is low so the bus stays quiet through reset.
    always_comb begin
        cpu_gnt  = 1'b0;
        scan_gnt = 1'b0;
        if (reset) begin
            if (blank) begin
                cpu_gnt  = cpu_req;
                scan_gnt = scan_req && !cpu_req;
            end else begin
                cpu_gnt  = force_cpu || (cpu_req && !scan_req);
                scan_gnt = scan_req && !force_cpu;
            end
        end
    end

    always_comb begin
        gnt_req = '0;
        if (cpu_gnt)
            gnt_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        else if (scan_gnt)
            gnt_req = '{we: 1'b0, addr: scan_addr, wdata: '0};
    end

    assign rd_issue = scan_gnt || (cpu_gnt && !cpu_we);

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve       <= '0;
            vram_en      <= 1'b0;
            vram_we      <= 1'b0;
            vram_addr    <= '0;
            vram_wdata   <= '0;
            vld_pipe     <= '0;
            own_pipe     <= '0;
            cpu_rdata_q  <= '0;
            scan_rdata_q <= '0;
        end else begin
            if (cpu_req && !cpu_gnt)
                starve <= (starve == STARVE_MAX) ? starve : starve + 8'd1;
            else
                starve <= '0;
            vram_en    <= cpu_gnt || scan_gnt;
            vram_we    <= gnt_req.we;
            vram_addr  <= gnt_req.addr;
            vram_wdata <= gnt_req.wdata;
            vld_pipe   <= {vld_pipe[STAGES-1:1], rd_issue};
            own_pipe   <= {own_pipe[STAGES-1:1], cpu_gnt};
            if (cpu_rvalid)  cpu_rdata_q  <= vram_rdata;
            if (scan_rvalid) scan_rdata_q <= vram_rdata;
        end
    end

    // Sync SRAM data arrives in the tag's final stage; bypass it, then hold it.
    assign cpu_rvalid  = vld_pipe[STAGES] && own_pipe[STAGES];
    assign scan_rvalid = vld_pipe[STAGES] && !own_pipe[STAGES];
    assign cpu_rdata   = cpu_rvalid  ? vram_rdata : cpu_rdata_q;
    assign scan_rdata  = scan_rvalid ? vram_rdata : scan_rdata_q;

`ifdef VGA_VRAM_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset || stat_clear) begin
            stat_cpu_wait <= '0;
            stat_scan_def <= '0;
        end else begin
            if (cpu_req && !cpu_gnt && stat_cpu_wait != '1)
                stat_cpu_wait <= stat_cpu_wait + 1'b1;
            if (!blank && scan_req && !scan_gnt && stat_scan_def != '1)
                stat_scan_def <= stat_scan_def + 1'b1;
        end
    end
`else
    logic unused_stat_clear;
    assign unused_stat_clear = stat_clear;
    assign stat_cpu_wait     = '0;
    assign stat_scan_def     = '0;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: per-scenario tasks plus a read-data scoreboard
// fed at grant time and drained by a monitor on rvalid.
module tb_vga_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hblank = 1'b0, vblank = 1'b0;
    logic        scan_req = 1'b0;
    logic [16:0] scan_addr = '0;
    logic        scan_gnt, scan_rvalid;
    logic [15:0] scan_rdata;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        vram_en, vram_we;
    logic [16:0] vram_addr;
    logic [15:0] vram_wdata;
    logic [15:0] vram_rdata = '0;
    logic        stat_clear = 1'b0;
    logic [15:0] stat_cpu_wait, stat_scan_def;

    vga_vram_arbiter #(.VRAM_DATA_WIDTH(16), .VRAM_ADDR_WIDTH(17),
                       .STARVE_LIMIT(8), .STAT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .hblank(hblank), .vblank(vblank),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
        .scan_rdata(scan_rdata), .scan_rvalid(scan_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .stat_clear(stat_clear), .stat_cpu_wait(stat_cpu_wait), .stat_scan_def(stat_scan_def)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit          cpu;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem    [0:131071];
    logic [15:0] shadow [0:131071];

    function automatic logic [15:0] dflt(input logic [16:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Sync SRAM model: read data one cycle after the strobe.
    always @(posedge clock) begin
        if (vram_en) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else         vram_rdata     <= mem[vram_addr];
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (cpu_rvalid || scan_rvalid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_rvalid: got cpu=%0b scan=%0b, expected none (cyc %0d)",
                             cpu_rvalid, scan_rvalid, cyc);
                end else begin
                    e = sb.pop_front();
                    if (cpu_rvalid !== e.cpu || scan_rvalid !== !e.cpu || cyc != e.due ||
                        (e.cpu ? cpu_rdata : scan_rdata) !== e.data) begin
                        fails++;
                        $display("FAIL rdata: got cpu_rv=%0b scan_rv=%0b data=%h cyc=%0d, expected cpu=%0b data=%h cyc=%0d",
                                 cpu_rvalid, scan_rvalid, e.cpu ? cpu_rdata : scan_rdata, cyc,
                                 e.cpu, e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                tests++;
                fails++;
                e = sb.pop_front();
                $display("FAIL missing_rvalid: got none at cyc %0d, expected cpu=%0b data=%h", cyc, e.cpu, e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Records the bench-predicted grants for this cycle.
    task automatic book(input bit s, input bit c);
        if (s) sb.push_back('{cpu: 1'b0, data: shadow[scan_addr], due: cyc + 2});
        if (c) begin
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else sb.push_back('{cpu: 1'b1, data: shadow[cpu_addr], due: cyc + 2});
        end
    endtask

    task automatic idle_inputs;
        scan_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        hblank = 1'b0; vblank = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic drain;
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle_inputs();
        repeat (2) tick();
        @(negedge clock);
        tests++;
        if ({scan_gnt, cpu_gnt, vram_en, vram_we, scan_rvalid, cpu_rvalid} !== 6'b0 ||
            vram_addr !== '0 || vram_wdata !== '0 || cpu_rdata !== '0 || scan_rdata !== '0 ||
            stat_cpu_wait !== '0 || stat_scan_def !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%0b%0b en=%0b we=%0b addr=%h rv=%0b%0b, expected all 0",
                     scan_gnt, cpu_gnt, vram_en, vram_we, vram_addr, scan_rvalid, cpu_rvalid);
        end
        tick();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic test_priority;
        scan_req = 1'b1; scan_addr = 17'h00010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00020;
        @(negedge clock);
        tests++;
        if (scan_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            fails++;
            $display("FAIL active_priority: got scan_gnt=%0b cpu_gnt=%0b, expected 1 0", scan_gnt, cpu_gnt);
        end
        book(1'b1, 1'b0);
        tick();
        idle_inputs();
        @(negedge clock);
        tests++;
        if (vram_en !== 1'b1 || vram_we !== 1'b0 || vram_addr !== 17'h00010) begin
            fails++;
            $display("FAIL scan_issue: got en=%0b we=%0b addr=%h, expected 1 0 00010", vram_en, vram_we, vram_addr);
        end
        drain();
    endtask

    task automatic test_starvation;
        scan_req = 1'b1; scan_addr = 17'h00040;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00100; cpu_wdata = 16'h1234;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 9; k++) begin
                @(negedge clock);
                tests++;
                if (cpu_gnt !== (k == 9) || scan_gnt !== (k != 9)) begin
                    fails++;
                    $display("FAIL starve_r%0d_k%0d: got cpu_gnt=%0b scan_gnt=%0b, expected %0b %0b",
                             r, k, cpu_gnt, scan_gnt, k == 9, k != 9);
                end
                book(k != 9, k == 9);
                tick();
                if (k != 9) scan_addr = scan_addr + 17'd1;
                else cpu_we = 1'b0;
            end
        end
        drain();
    endtask

    task automatic test_blank;
        scan_req = 1'b1; scan_addr = 17'h00080;
        cpu_req = 1'b1; cpu_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vblank = (i < 2); hblank = (i >= 2);
            cpu_addr = 17'h00200 + 17'(i); cpu_wdata = 16'hA000 + 16'(i);
            @(negedge clock);
            tests++;
            if (cpu_gnt !== 1'b1 || scan_gnt !== 1'b0) begin
                fails++;
                $display("FAIL blank_cpu_%0d: got cpu_gnt=%0b scan_gnt=%0b, expected 1 0", i, cpu_gnt, scan_gnt);
            end
            book(1'b0, 1'b1);
            tick();
        end
        cpu_req = 1'b0;
        @(negedge clock);
        tests++;
        if (scan_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            fails++;
            $display("FAIL blank_scan: got scan_gnt=%0b cpu_gnt=%0b, expected 1 0", scan_gnt, cpu_gnt);
        end
        book(1'b1, 1'b0);
        tick();
        drain();
    endtask

    task automatic test_blank_toggle;
        scan_req = 1'b1; scan_addr = 17'h000C0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00201;
        for (int i = 0; i < 5; i++) begin
            hblank = (i == 3);
            @(negedge clock);
            tests++;
            if (cpu_gnt !== (i == 3) || scan_gnt !== (i != 3)) begin
                fails++;
                $display("FAIL blank_toggle_%0d: got cpu_gnt=%0b scan_gnt=%0b, expected %0b %0b",
                         i, cpu_gnt, scan_gnt, i == 3, i != 3);
            end
            book(i != 3, i == 3);
            tick();
            if (i != 3) scan_addr = scan_addr + 17'd1;
            else cpu_addr = 17'h00202;
        end
        drain();
    endtask

    task automatic test_cpu_read;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h1ABCD;
        @(negedge clock);
        tests++;
        if (cpu_gnt !== 1'b1 || scan_gnt !== 1'b0) begin
            fails++;
            $display("FAIL read_gnt: got cpu_gnt=%0b scan_gnt=%0b, expected 1 0", cpu_gnt, scan_gnt);
        end
        book(1'b0, 1'b1);
        tick();
        cpu_req = 1'b0;
        @(negedge clock);
        tests++;
        if (vram_en !== 1'b1 || vram_we !== 1'b0 || vram_addr !== 17'h1ABCD) begin
            fails++;
            $display("FAIL read_issue: got en=%0b we=%0b addr=%h, expected 1 0 1abcd", vram_en, vram_we, vram_addr);
        end
        tick();
        @(negedge clock);
        tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF || scan_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL read_data: got rv=%0b data=%h scan_rv=%0b, expected 1 beef 0",
                     cpu_rvalid, cpu_rdata, scan_rvalid);
        end
        tick();
        @(negedge clock);
        tests++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL rdata_hold: got rv=%0b data=%h, expected 0 beef", cpu_rvalid, cpu_rdata);
        end
        drain();
    endtask

    task automatic test_reset_inflight;
        scan_req = 1'b1; scan_addr = 17'h00300;
        @(negedge clock);
        tests++;
        if (scan_gnt !== 1'b1) begin
            fails++;
            $display("FAIL inflight_gnt: got scan_gnt=%0b, expected 1", scan_gnt);
        end
        tick();
        scan_req = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (vram_en !== 1'b1) begin
            fails++;
            $display("FAIL inflight_issue: got vram_en=%0b, expected 1", vram_en);
        end
        tick();
        @(negedge clock);
        tests++;
        if ({scan_rvalid, cpu_rvalid, vram_en, vram_we, scan_gnt, cpu_gnt} !== 6'b0 ||
            vram_addr !== '0 || scan_rdata !== '0 || cpu_rdata !== '0) begin
            fails++;
            $display("FAIL inflight_drop: got scan_rv=%0b en=%0b addr=%h scan_rdata=%h cpu_rdata=%h, expected all 0",
                     scan_rvalid, vram_en, vram_addr, scan_rdata, cpu_rdata);
        end
        reset = 1'b1;
        tick();
        @(negedge clock);
        tests++;
        if (scan_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL inflight_late: got scan_rv=%0b cpu_rv=%0b, expected 0 0", scan_rvalid, cpu_rvalid);
        end
        drain();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 12; i++) begin
            vblank = (i < 8);
            cpu_req = (i < 8); cpu_we = (i < 4);
            cpu_addr = 17'h00400 + 17'(i % 4); cpu_wdata = 16'hC000 + 16'(i);
            scan_req = (i >= 8); scan_addr = 17'h00400 + 17'(i % 4);
            @(negedge clock);
            tests++;
            if (cpu_gnt !== (i < 8) || scan_gnt !== (i >= 8) || (i > 0 && vram_en !== 1'b1)) begin
                fails++;
                $display("FAIL b2b_%0d: got cpu_gnt=%0b scan_gnt=%0b en=%0b, expected %0b %0b en=1",
                         i, cpu_gnt, scan_gnt, vram_en, i < 8, i >= 8);
            end
            book(i >= 8, i < 8);
            tick();
        end
        drain();
    endtask

    task automatic test_stats;
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        scan_req = 1'b1; scan_addr = 17'h00500;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00600;
        for (int i = 0; i < 5; i++) begin
            book(1'b1, 1'b0);
            tick();
            scan_addr = scan_addr + 17'd1;
        end
        idle_inputs();
        @(negedge clock);
        tests++;
`ifdef VGA_VRAM_ARB_STATS_EN
        if (stat_cpu_wait !== 16'd5 || stat_scan_def !== 16'd0) begin
            fails++;
            $display("FAIL stat_count: got wait=%0d def=%0d, expected 5 0", stat_cpu_wait, stat_scan_def);
        end
`else
        if (stat_cpu_wait !== 16'd0 || stat_scan_def !== 16'd0) begin
            fails++;
            $display("FAIL stat_off: got wait=%0d def=%0d, expected 0 0", stat_cpu_wait, stat_scan_def);
        end
`endif
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        @(negedge clock);
        tests++;
        if (stat_cpu_wait !== 16'd0 || stat_scan_def !== 16'd0) begin
            fails++;
            $display("FAIL stat_clear: got wait=%0d def=%0d, expected 0 0", stat_cpu_wait, stat_scan_def);
        end
        drain();
    endtask

    initial begin
        for (int a = 0; a < 131072; a++) begin
            mem[a]    = dflt(17'(a));
            shadow[a] = dflt(17'(a));
        end
        mem[17'h1ABCD]    = 16'hBEEF;
        shadow[17'h1ABCD] = 16'hBEEF;
        #1;
        test_reset();
        test_priority();
        test_starvation();
        test_blank();
        test_blank_toggle();
        test_cpu_read();
        test_reset_inflight();
        test_back_to_back();
        test_stats();
        @(negedge clock);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got %0d pending reads, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
